// File: rtl/inv_sub_byte_seq_pkg.sv
// rtl/inv_sub_byte_seq_pkg.sv - shared AES constants, FSM type and S-box tables
//
// Purpose: common definitions for the AES SubBytes / InvSubBytes stages.
//   BYTE_W / NBYTES : byte width and number of bytes in an AES-128 state
//   state_e         : IDLE / RUN / DONE controller states
//   sbox_f()        : forward AES S-box lookup (encrypt side)
//   inv_sbox_f()    : inverse AES S-box lookup (decrypt side)
// Both tables live here so encrypt and decrypt datapaths share one source.

package inv_sub_byte_seq_pkg;

  localparam int BYTE_W = 8;
  localparam int NBYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX_T [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX_T [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    return SBOX_T[x];
  endfunction

  function automatic logic [7:0] inv_sbox_f(input logic [7:0] x);
    return INV_SBOX_T[x];
  endfunction

endpackage

// File: rtl/inv_sub_byte_seq_inv_sbox.sv
// rtl/inv_sub_byte_seq_inv_sbox.sv - single-byte AES inverse S-box lookup
//
// Purpose: purely combinational inverse S-box, one byte in, one byte out.
// Ports:
//   a : input  [7:0] byte to substitute
//   c : output [7:0] inv_sbox(a)

module inv_sbox
  import inv_sub_byte_seq_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] c
);

  assign c = inv_sbox_f(a);

endmodule

// File: rtl/inv_sub_byte_seq.sv
// rtl/inv_sub_byte_seq.sv - iterative AES-128 InvSubBytes stage with valid/ready
//
// Purpose: applies the AES inverse S-box to all 16 bytes of a 128-bit state,
// LANES bytes per cycle, over NSTEP = 16/LANES cycles.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake, in[127:120] is byte 0
//   in                  : state to substitute
//   out_valid/out_ready : output handshake
//   isb                 : substituted state, driven from the state register
//   busy                : high while substitution steps are running

module inv_sub_byte_seq
  import inv_sub_byte_seq_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] isb,
  output logic         busy
);

  localparam int NSTEP = NBYTES / LANES;
  localparam int CW    = $clog2(NSTEP) + 1;
  localparam int SW    = LANES * BYTE_W;
  localparam logic [CW-1:0] CNT_LAST = CW'(NSTEP - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_byte_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e         st_q;
  logic [CW-1:0]  cnt_q;
  logic [127:0]   state_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;

  // Byte 0 sits at the MSB end, so step cnt addresses the slice that starts
  // (NSTEP-1-cnt) slices above bit 0.
  logic [6:0]     base;
  logic [SW-1:0]  slice_cur;
  logic [SW-1:0]  slice_sub;

  always_comb begin
    base      = 7'((NSTEP - 1 - int'(cnt_q)) * SW);
    slice_cur = state_q[base +: SW];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_inv_sbox (
      .a (slice_cur[(LANES-1-l)*BYTE_W +: BYTE_W]),
      .c (slice_sub[(LANES-1-l)*BYTE_W +: BYTE_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ST_IDLE;
      cnt_q       <= '0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q    <= in;
            cnt_q      <= '0;
            st_q       <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q[base +: SW] <= slice_sub;
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            st_q        <= ST_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          // in_ready only rises after this edge, so no input can be taken
          // in the same cycle the result leaves.
          if (out_ready) begin
            st_q        <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          st_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign isb       = state_q;

endmodule

// File: tb/tb_inv_sub_byte_seq.sv
// tb/tb_inv_sub_byte_seq.sv - self-checking bench for inv_sub_byte_seq

module tb_inv_sub_byte_seq;

  typedef struct {
    string        nm;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv   [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         ordy [3];
  logic         bz   [3];
  logic [127:0] din  [3];
  logic [127:0] isb  [3];

  int tests = 0;
  int fails = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  always #5 clk = ~clk;

  function automatic int lanes_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 16);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_sub_byte_seq #(.LANES((g == 0) ? 4 : ((g == 1) ? 1 : 16))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in        (din[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .isb       (isb[g]),
      .busy      (bz[g])
    );
  end

  // Reference S-box from its definition: GF(2^8) inverse then affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] r = 8'h63;
    for (int i = 0; i < 5; i++) r ^= (b << i) | (b >> (8 - i));
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fwd_t[x] = affine(inv);
    end
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
  endtask

  function automatic logic [127:0] map_state(input logic [127:0] s, input bit inverse);
    logic [127:0] r;
    for (int b = 0; b < 16; b++)
      r[127-8*b -: 8] = inverse ? inv_t[s[127-8*b -: 8]] : fwd_t[s[127-8*b -: 8]];
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Offer one block to DUT k, check busy, latency and result; returns at the
  // first negedge where out_valid is seen.
  task automatic run_block(input int k, input logic [127:0] d, input logic [127:0] e,
                           input string nm);
    int to;
    int lat;
    int ns;
    ns = 16 / lanes_of(k);
    to = 0;
    while (!ir[k] && to < 100) begin
      @(negedge clk);
      to++;
    end
    iv[k]  = 1'b1;
    din[k] = d;
    @(negedge clk);
    iv[k] = 1'b0;
    check({nm, "_busy"}, 128'(bz[k]), 128'd1);
    lat = 0;
    while (!ov[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_int({nm, "_latency"}, lat, ns);
    check({nm, "_isb"}, isb[k], e);
    check({nm, "_in_ready_done"}, 128'(ir[k]), 128'd0);
  endtask

  vec_t         vecs [5];
  logic [127:0] blk  [3];
  logic [127:0] orig;
  int           cyc, last, sent, got, extra;
  bit           acc, outacc;

  initial begin
    vecs[0] = '{"fips_r1", FIPS_IN, FIPS_OUT};
    vecs[1] = '{"all_63", {16{8'h63}}, {16{8'h00}}};
    vecs[2] = '{"all_7c", {16{8'h7c}}, {16{8'h01}}};
    vecs[3] = '{"all_16", {16{8'h16}}, {16{8'hff}}};
    vecs[4] = '{"all_ed", {16{8'hed}}, {16{8'h53}}};

    build_tables();

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; din[k] = '0; ordy[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", 128'(ir[k]), 128'd1);
      check("rst_out_valid", 128'(ov[k]), 128'd0);
      check("rst_busy", 128'(bz[k]), 128'd0);
      check("rst_isb", isb[k], 128'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_block(0, vecs[i].din, vecs[i].exp, vecs[i].nm);

    // Backpressure in DONE, with a stray in_valid that must be ignored.
    @(negedge clk);
    ordy[0] = 1'b0;
    run_block(0, FIPS_IN, FIPS_OUT, "bp");
    iv[0]  = 1'b1;
    din[0] = ~FIPS_IN;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(ov[0]), 128'd1);
      check("bp_isb", isb[0], FIPS_OUT);
      check("bp_in_ready", 128'(ir[0]), 128'd0);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    check("bp_rel_out_valid", 128'(ov[0]), 128'd0);
    check("bp_rel_in_ready", 128'(ir[0]), 128'd1);
    check("bp_rel_isb_kept", isb[0], FIPS_OUT);

    // Reset while cnt == 2.
    iv[0]  = 1'b1;
    din[0] = FIPS_IN;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_in_ready", 128'(ir[0]), 128'd1);
    check("mrst_out_valid", 128'(ov[0]), 128'd0);
    check("mrst_busy", 128'(bz[0]), 128'd0);
    check("mrst_isb", isb[0], 128'd0);
    run_block(0, {16{8'hed}}, {16{8'h53}}, "post_rst");
    @(negedge clk);

    // Back-to-back: three queued blocks, out_ready held high.
    for (int i = 0; i < 3; i++) blk[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    cyc = 0; last = 0; sent = 0; got = 0;
    iv[0]  = 1'b1;
    din[0] = blk[0];
    while (got < 3 && cyc < 200) begin
      acc    = iv[0] && ir[0];
      outacc = ov[0] && ordy[0];
      if (outacc) begin
        check("b2b_isb", isb[0], map_state(blk[got], 1'b1));
        if (got > 0) check_int("b2b_period", cyc - last, 6);
        last = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 3) din[0] = blk[sent];
        else iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    check_int("b2b_count", got, 3);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov[0]) extra++;
    end
    check_int("b2b_extra", extra, 0);

    // Round trip through the reference forward stage, for LANES 4, 1 and 16.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        orig = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_block(k, map_state(orig, 1'b0), orig, $sformatf("rt_L%0d", lanes_of(k)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
